johnson_code_decoder_module: RTL and testbench

//   Receive-side companion of the team's N-bit Johnson (twisted-ring) counter.

---
 rtl/johnson_code_decoder_module_if.sv | 36 +++
 rtl/johnson_code_decoder_module.sv | 132 +++++++++++++
 tb/tb_johnson_code_decoder_module.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/johnson_code_decoder_module_if.sv
// Bus between a Johnson-counter sampler (master) and the decoder (slave).
//   code_valid  master->slave  code_in is sampled on this edge
//   code_in     master->slave  N-bit Johnson code word
//   valid_out   slave->master  1-cycle pulse, status refers to that sample
//   idx_out     slave->master  decoded state index 0..2N-1
//   onehot_out  slave->master  one-hot of idx_out (0 until first legal sample)
//   legal_out   slave->master  sample was a legal Johnson word
//   step_err_out slave->master legal word, but not previous index + 1
//   locked_out  slave->master  decoder is locked to the counter sequence
//   err_count_out slave->master saturating count of bad samples
interface johnson_code_decoder_module_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned ERR_W = 8
);
  localparam int unsigned IDX_W = $clog2(2 * N);

  logic             code_valid;
  logic [N-1:0]     code_in;
  logic             valid_out;
  logic [IDX_W-1:0] idx_out;
  logic [2*N-1:0]   onehot_out;
  logic             legal_out;
  logic             step_err_out;
  logic             locked_out;
  logic [ERR_W-1:0] err_count_out;

  modport master (
    output code_valid, code_in,
    input  valid_out, idx_out, onehot_out, legal_out, step_err_out, locked_out, err_count_out
  );

  modport slave (
    input  code_valid, code_in,
    output valid_out, idx_out, onehot_out, legal_out, step_err_out, locked_out, err_count_out
  );
endinterface

// File: rtl/johnson_code_decoder_module.sv
// Johnson (twisted-ring) code decoder: decodes a sampled N-bit Johnson word into a
// binary index and a one-hot vector, flags illegal words, counts bad samples
// (saturating) and tracks lock to the counter sequence.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - johnson_code_decoder_module_if.slave (sample in, registered status out)
// Optional feature macro: JOHNSON_DEC_STEP_CHECK_EN
//   Defined   : a legal word that is not reference index + 1 (mod 2N) is a step error.
//   Undefined : step_err_out is 0 and every legal word counts as good.
module johnson_code_decoder_module #(
  parameter int unsigned N        = 4,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned ERR_W    = 8
) (
  input logic                            clk,
  input logic                            rst,
  johnson_code_decoder_module_if.slave   bus
);
  localparam int unsigned IDX_W = $clog2(2 * N);
  localparam int unsigned M     = 2 * N;
  localparam logic [3:0]  LockCnt = 4'(LOCK_CNT);

`ifdef JOHNSON_DEC_STEP_CHECK_EN
  localparam bit StepCheckEn = 1'b1;
`else
  localparam bit StepCheckEn = 1'b0;
`endif

  typedef enum logic [0:0] {StUnlocked, StLocked} state_e;

  state_e           r_state;
  logic             r_valid;
  logic [IDX_W-1:0] r_idx;
  logic [M-1:0]     r_onehot;
  logic             r_legal;
  logic             r_step_err;
  logic [ERR_W-1:0] r_err;
  logic [3:0]       r_run;
  logic [IDX_W-1:0] r_ref;
  logic             r_ref_valid;

  int unsigned      w_pop;
  int unsigned      w_idx_int;
  logic [IDX_W-1:0] w_idx;
  logic [N-1:0]     w_canon;
  logic             w_legal;
  logic [M-1:0]     w_onehot;
  logic [IDX_W-1:0] w_ref_inc;
  logic             w_step_err;
  logic [3:0]       w_run_inc;

  // Decode: index from popcount and MSB, then legality by regenerating the
  // canonical word for that index and comparing.
  always_comb begin
    w_pop = 0;
    for (int i = 0; i < int'(N); i++) begin
      w_pop = w_pop + 32'(bus.code_in[i]);
    end
    // MSB set implies popcount >= 1, so M - w_pop stays within N..M-1.
    w_idx_int = bus.code_in[N-1] ? (M - w_pop) : w_pop;
    w_idx     = IDX_W'(w_idx_int);

    w_canon = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_idx_int <= N) w_canon[i] = (i < w_idx_int);
      else                w_canon[i] = (i >= (w_idx_int - N));
    end
    w_legal = (bus.code_in == w_canon);

    w_onehot        = '0;
    w_onehot[w_idx] = 1'b1;

    w_ref_inc  = (32'(r_ref) == M - 1) ? '0 : r_ref + 1'b1;
    w_step_err = StepCheckEn && w_legal && r_ref_valid && (w_idx != w_ref_inc);

    w_run_inc = (r_run >= LockCnt) ? LockCnt : r_run + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StUnlocked;
      r_valid     <= 1'b0;
      r_idx       <= '0;
      r_onehot    <= '0;
      r_legal     <= 1'b0;
      r_step_err  <= 1'b0;
      r_err       <= '0;
      r_run       <= '0;
      r_ref       <= '0;
      r_ref_valid <= 1'b0;
    end else begin
      r_valid <= bus.code_valid;
      if (bus.code_valid) begin
        r_legal    <= w_legal;
        r_step_err <= w_step_err;
        if (!w_legal) begin
          r_ref_valid <= 1'b0;
          r_run       <= '0;
          r_state     <= StUnlocked;
          if (r_err != '1) r_err <= r_err + 1'b1;
        end else begin
          r_idx       <= w_idx;
          r_onehot    <= w_onehot;
          r_ref       <= w_idx;
          r_ref_valid <= 1'b1;
          if (w_step_err) begin
            // A mis-step still counts as the first sample of a new run.
            r_run   <= 4'd1;
            r_state <= StUnlocked;
            if (r_err != '1) r_err <= r_err + 1'b1;
          end else begin
            r_run <= w_run_inc;
            case (r_state)
              StUnlocked: if (w_run_inc == LockCnt) r_state <= StLocked;
              StLocked:   r_state <= StLocked;
              default:    r_state <= StUnlocked;
            endcase
          end
        end
      end
    end
  end

  assign bus.valid_out     = r_valid;
  assign bus.idx_out       = r_idx;
  assign bus.onehot_out    = r_onehot;
  assign bus.legal_out     = r_legal;
  assign bus.step_err_out  = r_step_err;
  assign bus.locked_out    = (r_state == StLocked);
  assign bus.err_count_out = r_err;
endmodule

// File: tb/tb_johnson_code_decoder_module.sv
module tb_johnson_code_decoder_module;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  johnson_code_decoder_module_if #(.N(N), .ERR_W(8)) bus ();

  johnson_code_decoder_module #(.N(N), .LOCK_CNT(3), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef JOHNSON_DEC_STEP_CHECK_EN
  localparam bit StepOn = 1'b1;
`else
  localparam bit StepOn = 1'b0;
`endif

  // Drive one cycle of input on the falling edge, then settle after the rising edge.
  task automatic drive(input logic v, input logic [N-1:0] code, input logic r);
    @(negedge clk);
    bus.code_valid = v;
    bus.code_in    = code;
    rst            = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 4'b0001, 1'b1);  // rst wins over a valid sample
    drive(1'b0, 4'b0000, 1'b0);
    tests_run++;
    if ({bus.valid_out, bus.idx_out, bus.onehot_out, bus.legal_out, bus.step_err_out,
         bus.locked_out, bus.err_count_out} !== 22'd0) begin
      tests_failed++;
      $display("FAIL reset_all_zero got valid=%b idx=%0d oh=%h legal=%b step=%b lock=%b err=%0d exp all 0",
               bus.valid_out, bus.idx_out, bus.onehot_out, bus.legal_out, bus.step_err_out,
               bus.locked_out, bus.err_count_out);
    end
  endtask

  task automatic test_lock();
    logic [3:0] codes [3] = '{4'b0000, 4'b0001, 4'b0011};
    logic [7:0] ohs   [3] = '{8'h01, 8'h02, 8'h04};
    logic       locks [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, codes[i], 1'b0);
      tests_run++;
      if ({bus.valid_out, bus.legal_out, bus.idx_out, bus.onehot_out, bus.locked_out} !==
          {1'b1, 1'b1, 3'(i), ohs[i], locks[i]}) begin
        tests_failed++;
        $display("FAIL lock_seq[%0d] got v=%b legal=%b idx=%0d oh=%h lock=%b exp v=1 legal=1 idx=%0d oh=%h lock=%b",
                 i, bus.valid_out, bus.legal_out, bus.idx_out, bus.onehot_out, bus.locked_out,
                 i, ohs[i], locks[i]);
      end
    end
  endtask

  // Continues from idx 2 through the wrap 7 -> 0.
  task automatic test_wrap();
    logic [3:0] codes [6] = '{4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [2:0] idxs  [6] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, codes[i], 1'b0);
      tests_run++;
      if ({bus.idx_out, bus.step_err_out, bus.locked_out, bus.legal_out} !== {idxs[i], 3'b011}) begin
        tests_failed++;
        $display("FAIL wrap[%0d] got idx=%0d step=%b lock=%b legal=%b exp idx=%0d step=0 lock=1 legal=1",
                 i, bus.idx_out, bus.step_err_out, bus.locked_out, bus.legal_out, idxs[i]);
      end
    end
  endtask

  // Locked at idx 0: illegal word, then relock.
  task automatic test_illegal();
    drive(1'b1, 4'b0101, 1'b0);
    tests_run++;
    if ({bus.legal_out, bus.locked_out, bus.err_count_out, bus.idx_out, bus.onehot_out} !==
        {1'b0, 1'b0, 8'd1, 3'd0, 8'h01}) begin
      tests_failed++;
      $display("FAIL illegal got legal=%b lock=%b err=%0d idx=%0d oh=%h exp legal=0 lock=0 err=1 idx=0 oh=01",
               bus.legal_out, bus.locked_out, bus.err_count_out, bus.idx_out, bus.onehot_out);
    end
    drive(1'b1, 4'b0000, 1'b0);
    drive(1'b1, 4'b0001, 1'b0);
    tests_run++;
    if (bus.locked_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL relock_early got lock=%b exp 0", bus.locked_out);
    end
    drive(1'b1, 4'b0011, 1'b0);
    tests_run++;
    if ({bus.locked_out, bus.idx_out, bus.err_count_out, bus.step_err_out} !== {1'b1, 3'd2, 8'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL relock got lock=%b idx=%0d err=%0d step=%b exp lock=1 idx=2 err=1 step=0",
               bus.locked_out, bus.idx_out, bus.err_count_out, bus.step_err_out);
    end
  endtask

  task automatic test_step();
    logic [3:0] codes [4] = '{4'b0011, 4'b1111, 4'b1110, 4'b1100};
    logic [2:0] idxs  [4] = '{3'd2, 3'd4, 3'd5, 3'd6};
    logic       steps [4];
    logic       locks [4];
    logic [7:0] errs  [4];
    if (StepOn) begin
      steps = '{1'b0, 1'b1, 1'b0, 1'b0};
      locks = '{1'b0, 1'b0, 1'b0, 1'b1};
      errs  = '{8'd0, 8'd1, 8'd1, 8'd1};
    end else begin
      steps = '{1'b0, 1'b0, 1'b0, 1'b0};
      locks = '{1'b0, 1'b0, 1'b1, 1'b1};
      errs  = '{8'd0, 8'd0, 8'd0, 8'd0};
    end
    drive(1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, codes[i], 1'b0);
      tests_run++;
      if ({bus.idx_out, bus.step_err_out, bus.locked_out, bus.err_count_out} !==
          {idxs[i], steps[i], locks[i], errs[i]}) begin
        tests_failed++;
        $display("FAIL step[%0d] got idx=%0d step=%b lock=%b err=%0d exp idx=%0d step=%b lock=%b err=%0d",
                 i, bus.idx_out, bus.step_err_out, bus.locked_out, bus.err_count_out,
                 idxs[i], steps[i], locks[i], errs[i]);
      end
    end
  endtask

  task automatic test_gap();
    logic       vs  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] cs  [4] = '{4'b0001, 4'b0111, 4'b0111, 4'b0011};
    logic [2:0] ids [4] = '{3'd1, 3'd1, 3'd1, 3'd2};
    drive(1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(vs[i], cs[i], 1'b0);
      tests_run++;
      if ({bus.valid_out, bus.idx_out} !== {vs[i], ids[i]} ||
          (vs[i] && bus.step_err_out !== 1'b0)) begin
        tests_failed++;
        $display("FAIL gap[%0d] got v=%b idx=%0d step=%b exp v=%b idx=%0d step=0",
                 i, bus.valid_out, bus.idx_out, bus.step_err_out, vs[i], ids[i]);
      end
    end
  endtask

  task automatic test_saturate_and_reset();
    drive(1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 300; i++) drive(1'b1, 4'b1010, 1'b0);
    tests_run++;
    if ({bus.err_count_out, bus.legal_out, bus.locked_out} !== {8'd255, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL err_saturate got err=%0d legal=%b lock=%b exp err=255 legal=0 lock=0",
               bus.err_count_out, bus.legal_out, bus.locked_out);
    end
    drive(1'b1, 4'b1000, 1'b0);
    drive(1'b1, 4'b0000, 1'b0);
    drive(1'b1, 4'b0001, 1'b0);
    tests_run++;
    if ({bus.locked_out, bus.err_count_out, bus.idx_out} !== {1'b1, 8'd255, 3'd1}) begin
      tests_failed++;
      $display("FAIL relock_sat got lock=%b err=%0d idx=%0d exp lock=1 err=255 idx=1",
               bus.locked_out, bus.err_count_out, bus.idx_out);
    end
    drive(1'b1, 4'b0011, 1'b1);
    tests_run++;
    if ({bus.valid_out, bus.idx_out, bus.onehot_out, bus.legal_out, bus.step_err_out,
         bus.locked_out, bus.err_count_out} !== 22'd0) begin
      tests_failed++;
      $display("FAIL reset_locked got valid=%b idx=%0d oh=%h legal=%b step=%b lock=%b err=%0d exp all 0",
               bus.valid_out, bus.idx_out, bus.onehot_out, bus.legal_out, bus.step_err_out,
               bus.locked_out, bus.err_count_out);
    end
  endtask

  initial begin
    bus.code_valid = 1'b0;
    bus.code_in    = '0;
    test_reset();
    test_lock();
    test_wrap();
    test_illegal();
    test_step();
    test_gap();
    test_saturate_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end
endmodule
